// File: rtl/serial_minuend_restorer.sv
// serial_minuend_restorer: bit-serial rebuild of the minuend, A = D + B + Bin, one bit per clock, LSB first
// Ports: clk, rst (async, active-high); start requests a word and is accepted in IDLE or DONE;
//   d_in/b_in/bin_in are the difference, subtrahend and borrow-in; busy is high while shifting;
//   done pulses for one cycle when a_out/cout/ovf are updated; a_out/cout/ovf hold until the next word.
// Optional feature: define SERIAL_MINUEND_OVF_EN to build the signed overflow flag (ovf is 0 otherwise).
module serial_minuend_restorer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d, b_sh_q, b_sh_d, r_sh_q, r_sh_d, a_out_q, a_out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic c_q, c_d, cout_q, cout_d, done_q, done_d;
    logic s, c_nxt, load, last;
    logic [WIDTH-1:0] r_nxt;
    assign s = d_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_nxt = (d_sh_q[0] & b_sh_q[0]) | (c_q & (d_sh_q[0] ^ b_sh_q[0]));
    // r_nxt already contains the sum bit of this cycle, so the final word is taken from it
    assign r_nxt = {s, r_sh_q[WIDTH-1:1]};
    assign load = start && state_q != SHIFT;
    assign last = state_q == SHIFT && cnt_q == CNT_LAST;
    always_comb begin
        state_d = state_q;
        d_sh_d  = d_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        a_out_d = a_out_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = SHIFT;
            d_sh_d  = d_in;
            b_sh_d  = b_in;
            r_sh_d  = '0;
            cnt_d   = '0;
            c_d     = bin_in;
        end else if (state_q == SHIFT) begin
            d_sh_d = {1'b0, d_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            r_sh_d = r_nxt;
            cnt_d  = cnt_q + CW'(1);
            c_d    = c_nxt;
            if (last) begin
                state_d = DONE;
                a_out_d = r_nxt;
                cout_d  = c_nxt;
                done_d  = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            d_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            a_out_q <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_sh_q  <= d_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            a_out_q <= a_out_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end
`ifdef SERIAL_MINUEND_OVF_EN
    // operand MSBs are shifted out of d_sh/b_sh, so they are kept aside at load
    logic dmsb_q, dmsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
    always_comb begin
        dmsb_d = dmsb_q;
        bmsb_d = bmsb_q;
        ovf_d  = ovf_q;
        if (load) begin
            dmsb_d = d_in[WIDTH-1];
            bmsb_d = b_in[WIDTH-1];
        end else if (last) begin
            ovf_d = (dmsb_q == bmsb_q) && (r_nxt[WIDTH-1] != dmsb_q);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dmsb_q <= dmsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
    assign busy  = state_q == SHIFT;
    assign done  = done_q;
    assign a_out = a_out_q;
    assign cout  = cout_q;
endmodule

// File: tb/tb_serial_minuend_restorer.sv
// tb_serial_minuend_restorer: scoreboard bench for an 8-bit and a 4-bit serial_minuend_restorer
module tb_serial_minuend_restorer;
    typedef struct {
        logic [7:0] a;
        logic       c;
        logic       o;
        int         cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0, bin8 = 1'b0, start4 = 1'b0, bin4 = 1'b0;
    logic [7:0] d8 = '0, b8 = '0;
    logic [3:0] d4 = '0, b4 = '0;
    logic busy8, done8, cout8, ovf8, busy4, done4, cout4, ovf4;
    logic [7:0] a8;
    logic [3:0] a4;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q8[$];
    exp_t q4[$];
    serial_minuend_restorer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .d_in(d8), .b_in(b8), .bin_in(bin8),
        .busy(busy8), .done(done8), .a_out(a8), .cout(cout8), .ovf(ovf8)
    );
    serial_minuend_restorer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .d_in(d4), .b_in(b4), .bin_in(bin4),
        .busy(busy4), .done(done4), .a_out(a4), .cout(cout4), .ovf(ovf4)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask
    function automatic exp_t mk(input int w, input int d, input int b, input int bin, input int c);
        logic [31:0] sum, dv, bv;
        exp_t e;
        dv = d;
        bv = b;
        sum = dv + bv + 32'(bin);
        e.a = 8'(sum & ((32'd1 << w) - 1));
        e.c = sum[w];
`ifdef SERIAL_MINUEND_OVF_EN
        e.o = (dv[w-1] == bv[w-1]) && (sum[w-1] != dv[w-1]);
`else
        e.o = 1'b0;
`endif
        e.cyc = c;
        return e;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) chk("done8_spurious", 1, 0);
            else begin
                e = q8.pop_front();
                chk("a8", a8, e.a);
                chk("cout8", cout8, e.c);
                chk("ovf8", ovf8, e.o);
                chk("done8_cyc", cyc, e.cyc);
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) chk("done4_spurious", 1, 0);
            else begin
                e = q4.pop_front();
                chk("a4", a4, e.a);
                chk("cout4", cout4, e.c);
                chk("ovf4", ovf4, e.o);
                chk("done4_cyc", cyc, e.cyc);
            end
        end
    end
    task automatic run8(input logic [7:0] d, input logic [7:0] b, input logic bin);
        @(negedge clk);
        d8 = d;
        b8 = b;
        bin8 = bin;
        start8 = 1'b1;
        @(posedge clk);
        #1 q8.push_back(mk(8, d, b, bin, cyc + 8));
        @(negedge clk);
        start8 = 1'b0;
        chk("busy8", busy8, 1);
        repeat (10) @(negedge clk);
    endtask
    initial begin
        int e0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_a", a8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf", ovf8, 0);
        rst = 1'b0;
        run8(8'h05, 8'h03, 1'b0);
        run8(8'hFF, 8'h01, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h80, 8'h80, 1'b0);
        // back-to-back: start held high, second word reloads from DONE
        @(negedge clk);
        d8 = 8'h10;
        b8 = 8'h20;
        bin8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        q8.push_back(mk(8, 8'h10, 8'h20, 0, e0 + 8));
        q8.push_back(mk(8, 8'h7F, 8'h01, 0, e0 + 17));
        @(negedge clk);
        d8 = 8'h7F;
        b8 = 8'h01;
        repeat (9) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        // start while busy is ignored
        @(negedge clk);
        d8 = 8'h11;
        b8 = 8'h22;
        bin8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1 q8.push_back(mk(8, 8'h11, 8'h22, 0, cyc + 8));
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        d8 = 8'hAA;
        b8 = 8'h55;
        bin8 = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        // reset mid-word aborts with no done pulse
        d8 = 8'h33;
        b8 = 8'h44;
        bin8 = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_a", a8, 0);
        chk("abort_cout", cout8, 0);
        chk("abort_ovf", ovf8, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            d4 = 4'(i & 15);
            b4 = 4'((i >> 4) & 15);
            bin4 = 1'((i >> 8) & 1);
            start4 = 1'b1;
            @(posedge clk);
            #1 q4.push_back(mk(4, i & 15, (i >> 4) & 15, (i >> 8) & 1, cyc + 4));
            @(negedge clk);
            start4 = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("q8_drain", q8.size(), 0);
        chk("q4_drain", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
